// File: rtl/ps2_matrix_pkg.sv
// Shared constants for the PS/2 (scancode set 2) to ZX Spectrum matrix bridge.
// Holds the prefix and special scancodes, the matrix geometry, the CAPS/SYM
// positions and the composite-key identifiers. It also holds helpers that turn
// a row/col pair, or a composite id, into a flat matrix bit index.
package ps2_matrix_pkg;

  localparam logic [7:0] PREFIX_BRK   = 8'hF0;
  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PREFIX_PAUSE = 8'hE1;
  localparam logic [7:0] SC_F12       = 8'h07;
  localparam logic [7:0] SC_RSHIFT    = 8'h59;

  localparam int NROWS = 8;
  localparam int NCOLS = 5;
  localparam int NKEYS = NROWS * NCOLS;
  localparam int NCOMP = 5;

  // Bytes discarded after E1 so the rest of the Pause sequence never decodes.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam logic [2:0] CAPS_ROW = 3'd0;
  localparam logic [2:0] CAPS_COL = 3'd0;
  localparam logic [2:0] SYM_ROW  = 3'd7;
  localparam logic [2:0] SYM_COL  = 3'd1;

  localparam logic [2:0] COMP_LEFT  = 3'd0;
  localparam logic [2:0] COMP_DOWN  = 3'd1;
  localparam logic [2:0] COMP_UP    = 3'd2;
  localparam logic [2:0] COMP_RIGHT = 3'd3;
  localparam logic [2:0] COMP_BKSP  = 3'd4;

  function automatic logic [5:0] key_idx(input logic [2:0] row, input logic [2:0] col);
    return ({3'b000, row} * 6'd5) + {3'b000, col};
  endfunction

  // Digit bit that each composite key presses alongside CAPS.
  function automatic logic [5:0] comp_idx(input logic [2:0] id);
    case (id)
      COMP_LEFT:  comp_idx = key_idx(3'd3, 3'd4); // 5
      COMP_DOWN:  comp_idx = key_idx(3'd4, 3'd4); // 6
      COMP_UP:    comp_idx = key_idx(3'd4, 3'd3); // 7
      COMP_RIGHT: comp_idx = key_idx(3'd4, 3'd2); // 8
      default:    comp_idx = key_idx(3'd4, 3'd0); // 0
    endcase
  endfunction

endpackage

// File: rtl/ps2_matrix_map.sv
// Combinational scancode lookup.
// Ports:
//   ext       in  - the key event came after an E0 prefix
//   code      in  - scancode byte of the key event
//   valid     out - code maps to a plain matrix key or to a composite key
//   row, col  out - matrix position of a plain key
//   composite out - code is a composite key (CAPS + digit)
//   comp_id   out - which composite key
module ps2_matrix_map
  import ps2_matrix_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       valid,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       composite,
  output logic [2:0] comp_id
);

  always_comb begin
    valid     = 1'b1;
    row       = 3'd0;
    col       = 3'd0;
    composite = 1'b0;
    comp_id   = 3'd0;
    if (!ext) begin
      case (code)
        8'h12, 8'h59: begin row = CAPS_ROW; col = CAPS_COL; end
        8'h1A: begin row = 3'd0; col = 3'd1; end
        8'h22: begin row = 3'd0; col = 3'd2; end
        8'h21: begin row = 3'd0; col = 3'd3; end
        8'h2A: begin row = 3'd0; col = 3'd4; end
        8'h1C: begin row = 3'd1; col = 3'd0; end
        8'h1B: begin row = 3'd1; col = 3'd1; end
        8'h23: begin row = 3'd1; col = 3'd2; end
        8'h2B: begin row = 3'd1; col = 3'd3; end
        8'h34: begin row = 3'd1; col = 3'd4; end
        8'h15: begin row = 3'd2; col = 3'd0; end
        8'h1D: begin row = 3'd2; col = 3'd1; end
        8'h24: begin row = 3'd2; col = 3'd2; end
        8'h2D: begin row = 3'd2; col = 3'd3; end
        8'h2C: begin row = 3'd2; col = 3'd4; end
        8'h16: begin row = 3'd3; col = 3'd0; end
        8'h1E: begin row = 3'd3; col = 3'd1; end
        8'h26: begin row = 3'd3; col = 3'd2; end
        8'h25: begin row = 3'd3; col = 3'd3; end
        8'h2E: begin row = 3'd3; col = 3'd4; end
        8'h45: begin row = 3'd4; col = 3'd0; end
        8'h46: begin row = 3'd4; col = 3'd1; end
        8'h3E: begin row = 3'd4; col = 3'd2; end
        8'h3D: begin row = 3'd4; col = 3'd3; end
        8'h36: begin row = 3'd4; col = 3'd4; end
        8'h4D: begin row = 3'd5; col = 3'd0; end
        8'h44: begin row = 3'd5; col = 3'd1; end
        8'h43: begin row = 3'd5; col = 3'd2; end
        8'h3C: begin row = 3'd5; col = 3'd3; end
        8'h35: begin row = 3'd5; col = 3'd4; end
        8'h5A: begin row = 3'd6; col = 3'd0; end
        8'h4B: begin row = 3'd6; col = 3'd1; end
        8'h42: begin row = 3'd6; col = 3'd2; end
        8'h3B: begin row = 3'd6; col = 3'd3; end
        8'h33: begin row = 3'd6; col = 3'd4; end
        8'h29: begin row = 3'd7; col = 3'd0; end
        8'h14: begin row = SYM_ROW; col = SYM_COL; end
        8'h3A: begin row = 3'd7; col = 3'd2; end
        8'h31: begin row = 3'd7; col = 3'd3; end
        8'h32: begin row = 3'd7; col = 3'd4; end
        8'h66: begin composite = 1'b1; comp_id = COMP_BKSP; end
        default: valid = 1'b0;
      endcase
    end else begin
      // E0 12 / E0 59 (fake shifts) fall through to default on purpose.
      case (code)
        8'h14: begin row = SYM_ROW; col = SYM_COL; end
        8'h5A: begin row = 3'd6; col = 3'd0; end
        8'h6B: begin composite = 1'b1; comp_id = COMP_LEFT;  end
        8'h72: begin composite = 1'b1; comp_id = COMP_DOWN;  end
        8'h75: begin composite = 1'b1; comp_id = COMP_UP;    end
        8'h74: begin composite = 1'b1; comp_id = COMP_RIGHT; end
        default: valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_matrix.sv
// PS/2 set-2 scancode stream to 40-key ZX Spectrum keyboard matrix.
// Ports:
//   clock, reset - system clock, asynchronous active-low reset
//   ce           - clock enable shared with the PS/2 receiver
//   strb, code   - one-ce-cycle byte strobe and scancode from the receiver
//   addr         - CPU A15..A8; a row is selected when its bit is 0
//   keys         - active-low column data D4..D0 for the selected rows
//   f12          - one-ce-cycle pulse on an F12 make (host reset request)
module ps2_matrix
  import ps2_matrix_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       strb,
  input  logic [7:0] code,
  input  logic [7:0] addr,
  output logic [4:0] keys,
  output logic       f12
);

  // Input byte register: the decode runs one ce edge after the strobe.
  logic       strb_q;
  logic [7:0] code_q;

  logic [NKEYS-1:0] mat_q, mat_d;   // plain keys, 0 = pressed; CAPS bit unused
  logic [NCOMP-1:0] comp_q, comp_d; // composite keys held
  logic             lsh_q, lsh_d, rsh_q, rsh_d;
  logic             brk_q, brk_d, ext_q, ext_d;
  logic [2:0]       skip_q, skip_d;
  logic             f12_q, f12_d;

  logic       map_valid, map_comp;
  logic [2:0] map_row, map_col, map_id;

  ps2_matrix_map u_map (
    .ext       (ext_q),
    .code      (code_q),
    .valid     (map_valid),
    .row       (map_row),
    .col       (map_col),
    .composite (map_comp),
    .comp_id   (map_id)
  );

  always_comb begin
    mat_d  = mat_q;
    comp_d = comp_q;
    lsh_d  = lsh_q;
    rsh_d  = rsh_q;
    brk_d  = brk_q;
    ext_d  = ext_q;
    skip_d = skip_q;
    f12_d  = 1'b0;
    if (strb_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (code_q == PREFIX_BRK) begin
        brk_d = 1'b1;
      end else if (code_q == PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (code_q == PREFIX_PAUSE) begin
        skip_d = PAUSE_SKIP;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        f12_d = (code_q == SC_F12) && !brk_q;
        if (map_valid) begin
          if (map_comp) begin
            comp_d[map_id] = !brk_q;
          end else if (map_row == CAPS_ROW && map_col == CAPS_COL) begin
            // Both shifts land on CAPS; each is tracked on its own.
            if (code_q == SC_RSHIFT) rsh_d = !brk_q;
            else                     lsh_d = !brk_q;
          end else begin
            mat_d[key_idx(map_row, map_col)] = brk_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      strb_q <= 1'b0;
      code_q <= 8'h00;
      mat_q  <= '1;
      comp_q <= '0;
      lsh_q  <= 1'b0;
      rsh_q  <= 1'b0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      skip_q <= 3'd0;
      f12_q  <= 1'b0;
    end else if (ce) begin
      strb_q <= strb;
      code_q <= code;
      mat_q  <= mat_d;
      comp_q <= comp_d;
      lsh_q  <= lsh_d;
      rsh_q  <= rsh_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      skip_q <= skip_d;
      f12_q  <= f12_d;
    end
  end

  // Effective matrix: plain keys merged with CAPS sources and composite digits,
  // so a digit stays down while either its own key or a composite holds it.
  logic [NKEYS-1:0] eff;
  always_comb begin
    eff = mat_q;
    eff[key_idx(CAPS_ROW, CAPS_COL)] = !(lsh_q || rsh_q || (|comp_q));
    for (int i = 0; i < NCOMP; i++) begin
      if (comp_q[i]) eff[comp_idx(3'(i))] = 1'b0;
    end
  end

  // Selected rows are ANDed, as on the real matrix's shared column lines.
  logic [4:0] col_sel;
  always_comb begin
    col_sel = 5'h1F;
    for (int r = 0; r < NROWS; r++) begin
      if (!addr[r]) col_sel = col_sel & eff[r*NCOLS +: NCOLS];
    end
  end

  assign keys = col_sel;
  assign f12  = f12_q;

endmodule

// File: tb/tb_ps2_matrix.sv
module tb_ps2_matrix;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce    = 1'b1;
  logic       strb  = 1'b0;
  logic [7:0] code  = 8'h00;
  logic [7:0] addr  = 8'hFF;
  logic [4:0] keys;
  logic       f12;

  int n_checks = 0;
  int n_fail   = 0;
  int f12_cnt  = 0;

  logic [7:0] exp_q[$];

  ps2_matrix dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .strb  (strb),
    .code  (code),
    .addr  (addr),
    .keys  (keys),
    .f12   (f12)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (f12) f12_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s obs=%02h req=%02h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    strb = 1'b1;
    code = b;
    @(negedge clock);
    strb = 1'b0;
    idle(1);
  endtask

  // Expected value goes on the scoreboard when the row select is driven and
  // is compared once the combinational read has settled.
  task automatic rd(input string tag, input logic [7:0] a, input logic [4:0] e);
    logic [7:0] got;
    exp_q.push_back({3'b000, e});
    addr = a;
    #1;
    got = exp_q.pop_front();
    check_val(tag, {3'b000, keys}, got);
  endtask

  task automatic f12_chk(input string tag, input int e);
    exp_q.push_back(8'(e));
    idle(4);
    check_val(tag, 8'(f12_cnt), exp_q.pop_front());
  endtask

  initial begin
    idle(3);
    reset = 1'b1;
    idle(2);

    rd("rst_fe", 8'hFE, 5'h1F);
    rd("rst_00", 8'h00, 5'h1F);

    send(8'h1C); idle(1);
    rd("a_fd", 8'hFD, 5'h1E);
    rd("a_fe", 8'hFE, 5'h1F);
    send(8'hF0); send(8'h1C); idle(1);
    rd("a_rel", 8'hFD, 5'h1F);

    send(8'h12); send(8'hE0); send(8'h75); idle(1);
    rd("up_caps", 8'hFE, 5'h1E);
    rd("up_7", 8'hEF, 5'h17);
    send(8'hE0); send(8'hF0); send(8'h75); idle(1);
    rd("up_rel_caps", 8'hFE, 5'h1E);
    rd("up_rel_7", 8'hEF, 5'h1F);
    send(8'hF0); send(8'h12); idle(1);
    rd("lsh_rel", 8'hFE, 5'h1F);

    send(8'h12); send(8'h59); send(8'hF0); send(8'h12); idle(1);
    rd("rsh_held", 8'hFE, 5'h1E);
    send(8'hF0); send(8'h59); idle(1);
    rd("rsh_rel", 8'hFE, 5'h1F);

    send(8'h45); send(8'h66); idle(1);
    rd("bksp_caps", 8'hFE, 5'h1E);
    send(8'hF0); send(8'h66); idle(1);
    rd("bksp_0", 8'hEF, 5'h1E);
    rd("bksp_nocaps", 8'hFE, 5'h1F);
    send(8'hF0); send(8'h45); idle(1);
    rd("zero_rel", 8'hEF, 5'h1F);

    send(8'hE0); send(8'h74); idle(1);
    rd("right_8", 8'hEF, 5'h1B);
    send(8'hE0); send(8'hF0); send(8'h74); idle(1);
    rd("right_rel", 8'hEF, 5'h1F);

    send(8'hE1); send(8'h14); send(8'h77);
    rd("pause_mid", 8'h7F, 5'h1F);
    send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); idle(1);
    rd("pause_nosym", 8'h7F, 5'h1F);
    send(8'h29); idle(1);
    rd("pause_space", 8'h7F, 5'h1E);
    send(8'hF0); send(8'h29);

    send(8'hE0); send(8'h14); idle(1);
    rd("rctrl_sym", 8'h7F, 5'h1D);
    send(8'hE0); send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h12); idle(1);
    rd("fake_shift", 8'h00, 5'h1F);

    send(8'hF0);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    send(8'h1A); idle(1);
    rd("rst_mid", 8'hFE, 5'h1D);

    send(8'h1A); send(8'h1A); send(8'hF0); send(8'h1A); idle(1);
    rd("typematic", 8'hFE, 5'h1F);
    send(8'hF0); send(8'h1B); idle(1);
    rd("brk_unheld", 8'h00, 5'h1F);

    f12_cnt = 0;
    send(8'h07);
    f12_chk("f12_make", 1);
    f12_cnt = 0;
    send(8'hF0); send(8'h07);
    f12_chk("f12_break", 0);

    send(8'h1A); send(8'h29); idle(1);
    rd("multi_row", 8'h00, 5'h1C);
    rd("idle_ff", 8'hFF, 5'h1F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
